// File: rtl/muldiv_iter_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// FSM state encoding and small opcode decode helpers.
package muldiv_iter_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULT  = 2'b00,
        MD_OP_MULTU = 2'b01,
        MD_OP_DIV   = 2'b10,
        MD_OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_S_IDLE = 2'b00,
        MD_S_CALC = 2'b01,
        MD_S_FIX  = 2'b10,
        MD_S_DONE = 2'b11
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// Request/result bundle between the Execute stage and muldiv_iter.
interface muldiv_iter_if
    import muldiv_iter_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic               start_i;
    md_op_e             op_i;
    logic [WIDTH-1:0]   opa_i;
    logic [WIDTH-1:0]   opb_i;
    logic               annul_i;
    logic               stall_o;
    logic               ready_o;
    logic [2*WIDTH-1:0] result_o;

    modport master (
        output start_i, op_i, opa_i, opb_i, annul_i,
        input  stall_o, ready_o, result_o
    );

    modport slave (
        input  start_i, op_i, opa_i, opb_i, annul_i,
        output stall_o, ready_o, result_o
    );
endinterface

// File: rtl/muldiv_iter_cond_neg.sv
// Conditional two's-complement negate: y = neg ? -a : a.
module cond_neg #(
    parameter int N = 32
) (
    input  logic         neg,
    input  logic [N-1:0] a,
    output logic [N-1:0] y
);
    // Invert-and-increment when neg is set, pass through otherwise.
    always_comb begin
        y = neg ? (~a + N'(1)) : a;
    end
endmodule

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply and restoring divide, one bit per cycle.
// acc_q holds {hi, lo}: product accumulator for multiply, {remainder, quotient}
// for divide. opr_q holds the magnitude that is added (multiplicand) or
// subtracted (divisor) each iteration.
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_iter_if.slave  md
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    md_state_e          state_q, state_d;
    logic               div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opr_q, opr_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
    logic [2*WIDTH-1:0] mul_step, div_step;

    assign sign_a = op_is_signed(md.op_i) & md.opa_i[WIDTH-1];
    assign sign_b = op_is_signed(md.op_i) & md.opb_i[WIDTH-1];

    cond_neg #(.N(WIDTH))   u_abs_a (.neg(sign_a),    .a(md.opa_i),            .y(abs_a));
    cond_neg #(.N(WIDTH))   u_abs_b (.neg(sign_b),    .a(md.opb_i),            .y(abs_b));
    cond_neg #(.N(2*WIDTH)) u_prod  (.neg(neg_res_q), .a(acc_q),               .y(prod_fix));
    cond_neg #(.N(WIDTH))   u_quo   (.neg(neg_res_q), .a(acc_q[WIDTH-1:0]),    .y(quo_fix));
    cond_neg #(.N(WIDTH))   u_rem   (.neg(neg_rem_q), .a(acc_q[2*WIDTH-1:WIDTH]), .y(rem_fix));

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opr_q} : '0);
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        rem_diff = rem_sh - {1'b0, opr_q};
        div_step = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0}
                                   : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    // Control FSM and datapath next-state.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        opr_d     = opr_q;
        result_d  = result_q;
        ready_d   = 1'b0;
        case (state_q)
            MD_S_IDLE: begin
                if (md.start_i && !md.annul_i) begin
                    div_d     = op_is_div(md.op_i);
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    cnt_d     = '0;
                    if (op_is_div(md.op_i)) begin
                        opr_d = abs_b;
                        acc_d = {{WIDTH{1'b0}}, abs_a};
                    end else begin
                        opr_d = abs_a;
                        acc_d = {{WIDTH{1'b0}}, abs_b};
                    end
                    if (op_is_div(md.op_i) && md.opb_i == '0) begin
                        result_d = {md.opa_i, {WIDTH{1'b1}}};
                        ready_d  = 1'b1;
                        state_d  = MD_S_DONE;
                    end else begin
                        state_d  = MD_S_CALC;
                    end
                end
            end
            MD_S_CALC: begin
                if (md.annul_i) begin
                    state_d = MD_S_IDLE;
                end else begin
                    acc_d = div_q ? div_step : mul_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = MD_S_FIX;
                    end
                end
            end
            MD_S_FIX: begin
                if (md.annul_i) begin
                    state_d = MD_S_IDLE;
                end else begin
                    result_d = div_q ? {rem_fix, quo_fix} : prod_fix;
                    ready_d  = 1'b1;
                    state_d  = MD_S_DONE;
                end
            end
            default: begin
                state_d = MD_S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= MD_S_IDLE;
            div_q     <= 1'b0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            opr_q     <= '0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            opr_q     <= opr_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    // Stall is gated by reset so it drops the moment reset is asserted.
    assign md.stall_o  = rst & (((state_q == MD_S_IDLE) & md.start_i & ~md.annul_i)
                                | (state_q == MD_S_CALC) | (state_q == MD_S_FIX));
    assign md.ready_o  = ready_q;
    assign md.result_o = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter at WIDTH=32: vector table, random
// operands against a reference model, annul and reset corner sequences.
`timescale 1ns/1ps
module tb_muldiv_iter;
    import muldiv_iter_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_iter_if #(.WIDTH(W)) bus ();
    muldiv_iter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .md(bus));

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] sb[$];
    logic [63:0] last_res;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sbv, q, r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            MD_OP_MULT:  return 64'(sa * sbv);
            MD_OP_MULTU: return {32'b0, a} * {32'b0, b};
            MD_OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                q = sa / sbv;
                r = sa % sbv;
                return {32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Scoreboard: every ready pulse pops and compares one expected result.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.ready_o === 1'b1) begin
            if (sb.size() == 0) check("ready_unexpected", 64'(bus.ready_o), 64'(0));
            else                check("result", bus.result_o, sb.pop_front());
        end
    end

    task automatic do_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat, input string tag);
        bit got = 0;
        bit stall_ok = 1;
        int k_got = 0;
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.opa_i   = a;
        bus.opb_i   = b;
        sb.push_back(exp);
        @(negedge clk);
        check({tag, "_stall_c0"}, 64'(bus.stall_o), 64'(1));
        check({tag, "_ready_c0"}, 64'(bus.ready_o), 64'(0));
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.opa_i   = $urandom;
        bus.opb_i   = $urandom;
        for (int k = 1; k <= 60 && !got; k++) begin
            @(negedge clk);
            if (bus.ready_o === 1'b1) begin
                got   = 1;
                k_got = k;
                check({tag, "_stall_done"}, 64'(bus.stall_o), 64'(0));
            end else if (bus.stall_o !== 1'b1) begin
                stall_ok = 0;
            end
        end
        check({tag, "_timeout"}, 64'(got), 64'(1));
        check({tag, "_latency"}, 64'(k_got), 64'(lat));
        check({tag, "_stall_run"}, 64'(stall_ok), 64'(1));
        last_res = exp;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ready_seen;
        md_op_e op;
        logic [31:0] a, b;

        bus.start_i = 1'b0;
        bus.op_i    = MD_OP_MULT;
        bus.opa_i   = '0;
        bus.opb_i   = '0;
        bus.annul_i = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #5;
        check("rst_stall",  64'(bus.stall_o), 64'(0));
        check("rst_ready",  64'(bus.ready_o), 64'(0));
        check("rst_result", bus.result_o,     64'(0));
        #10 rst = 1'b1;

        vecs.push_back('{MD_OP_MULT,  32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB, 34});
        vecs.push_back('{MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 34});
        vecs.push_back('{MD_OP_DIVU,  32'd100,      32'd7,        64'h00000002_0000000E, 34});
        vecs.push_back('{MD_OP_DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 34});
        vecs.push_back('{MD_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34});
        vecs.push_back('{MD_OP_DIVU,  32'd5,        32'd0,        64'h00000005_FFFFFFFF, 1});
        vecs.push_back('{MD_OP_DIV,   32'hFFFFFFFB, 32'd0,        64'hFFFFFFFB_FFFFFFFF, 1});
        vecs.push_back('{MD_OP_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 34});
        vecs.push_back('{MD_OP_MULT,  32'hFFFFFFFF, 32'd1,        64'hFFFFFFFF_FFFFFFFF, 34});
        vecs.push_back('{MD_OP_DIV,   32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34});
        vecs.push_back('{MD_OP_MULTU, 32'd0,        32'h12345678, 64'h00000000_00000000, 34});
        vecs.push_back('{MD_OP_DIVU,  32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 34});
        vecs.push_back('{MD_OP_DIV,   32'hFFFFFFF8, 32'd3,        64'hFFFFFFFE_FFFFFFFE, 34});
        vecs.push_back('{MD_OP_MULT,  32'd12345,    32'hFFFFFC18, 64'hFFFFFFFF_FF43A158, 34});

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            op = md_op_e'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i == 3) ? 32'd0 : $urandom >> $urandom_range(0, 28);
            do_op(op, a, b, model(op, a, b),
                  (op_is_div(op) && b == 32'd0) ? 1 : 34, $sformatf("rnd%0d", i));
        end

        // start together with annul in IDLE is suppressed
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.annul_i = 1'b1;
        bus.op_i = MD_OP_MULTU; bus.opa_i = 32'd3; bus.opb_i = 32'd4;
        @(negedge clk);
        check("idle_annul_stall", 64'(bus.stall_o), 64'(0));
        @(posedge clk); #1;
        bus.start_i = 1'b0; bus.annul_i = 1'b0;
        ready_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ready_o === 1'b1) ready_seen = 1;
        end
        check("idle_annul_noready", 64'(ready_seen), 64'(0));
        check("idle_annul_result",  bus.result_o, last_res);

        // annul in CALC cycle 10
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.op_i = MD_OP_MULTU; bus.opa_i = 32'd11; bus.opb_i = 32'd13;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.annul_i = 1'b1;
        @(negedge clk);
        check("annul_c10_stall", 64'(bus.stall_o), 64'(1));
        @(posedge clk); #1;
        bus.annul_i = 1'b0;
        @(negedge clk);
        check("annul_c11_stall", 64'(bus.stall_o), 64'(0));
        ready_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ready_o === 1'b1) ready_seen = 1;
        end
        check("annul_noready", 64'(ready_seen), 64'(0));
        check("annul_result",  bus.result_o, last_res);
        do_op(MD_OP_DIVU, 32'd9, 32'd3, 64'h00000000_00000003, 34, "post_annul");

        // asynchronous reset in the middle of CALC
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.op_i = MD_OP_MULTU; bus.opa_i = 32'd5; bus.opb_i = 32'd5;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_stall",  64'(bus.stall_o), 64'(0));
        check("midrst_ready",  64'(bus.ready_o), 64'(0));
        check("midrst_result", bus.result_o,     64'(0));
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b1;
        do_op(MD_OP_MULT, 32'd2, 32'd3, 64'h00000000_00000006, 34, "post_rst");

        repeat (5) @(posedge clk);
        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
